// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared pedestrian-crossing types and default timing constants
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SERVED = 2'd2,
        GAP    = 2'd3
    } ped_state_t;

    localparam int DEBOUNCE_CYC_DEF = 1000000;
    localparam int DB_W_DEF         = 20;
    localparam int GAP_S_DEF        = 10;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and clean rising-edge pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int DB_W         = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_clean,
    output logic btn_rise
);

    logic            sync1;
    logic            sync2;
    logic            clean_d;
    logic [DB_W-1:0] cnt;

    // The counter only runs while the synchronised level disagrees with btn_clean,
    // so any return to the old level restarts the qualification window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            clean_d   <= 1'b0;
            btn_clean <= 1'b0;
            cnt       <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            clean_d <= btn_clean;
            if (sync2 == btn_clean) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYC)) begin
                btn_clean <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    assign btn_rise = btn_clean & ~clean_d;

endmodule

// File: rtl/ped_request.sv
// rtl/ped_request.sv - pedestrian button to request/acknowledge handshake with post-walk cooldown
module ped_request
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int DB_W         = DB_W_DEF,
    parameter int GAP_S        = GAP_S_DEF
) (
    input  logic s_clk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic btn_raw,
    input  logic walk_busy,
    input  logic ped_ack,
    output logic ped_req,
    output logic req_led,
    output logic btn_clean
);

    ped_state_t state;
    ped_state_t state_nxt;
    logic [7:0] gap_cnt;
    logic [7:0] gap_nxt;
    logic       pending;
    logic       pending_nxt;
    logic       ack_q;
    logic       busy_q;
    logic       press;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .DB_W        (DB_W)
    ) u_debounce (
        .clk      (s_clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_clean(btn_clean),
        .btn_rise (press)
    );

    // Acks are only captured while a request is outstanding, so a stray ack
    // arriving just before ARMED cannot cancel the next request.
    always_ff @(posedge s_clk) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= 8'd0;
            pending <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            pending <= pending_nxt;
            ack_q   <= ped_ack && (state == ARMED);
            busy_q  <= walk_busy;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_nxt     = gap_cnt;
        pending_nxt = pending;
        ped_req     = 1'b0;
        req_led     = 1'b0;
        case (state)
            IDLE: begin
                if (press) state_nxt = ARMED;
            end
            ARMED: begin
                ped_req = 1'b1;
                req_led = 1'b1;
                if (ack_q) state_nxt = SERVED;
            end
            SERVED: begin
                if (busy_q && !walk_busy) begin
                    state_nxt = GAP;
                    gap_nxt   = 8'(GAP_S);
                end
            end
            GAP: begin
                if (press) pending_nxt = 1'b1;
                if (tick_1hz) begin
                    if (gap_cnt <= 8'd1) begin
                        gap_nxt     = 8'd0;
                        state_nxt   = (pending || press) ? ARMED : IDLE;
                        pending_nxt = 1'b0;
                    end else begin
                        gap_nxt = gap_cnt - 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ped_request.sv
// tb/tb_ped_request.sv - directed self-checking bench for ped_request
module tb_ped_request;

    logic s_clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 1'b0;
    logic btn_raw = 1'b0;
    logic walk_busy = 1'b0;
    logic ped_ack = 1'b0;
    logic ped_req;
    logic req_led;
    logic btn_clean;

    int vectors = 0;
    int miscompares = 0;

    ped_request #(
        .DEBOUNCE_CYC(4),
        .DB_W        (4),
        .GAP_S       (3)
    ) dut (
        .s_clk    (s_clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_raw  (btn_raw),
        .walk_busy(walk_busy),
        .ped_ack  (ped_ack),
        .ped_req  (ped_req),
        .req_led  (req_led),
        .btn_clean(btn_clean)
    );

    always #5 s_clk = ~s_clk;

    task automatic step(input int n);
        repeat (n) @(posedge s_clk);
        #1;
    endtask

    task automatic press_hold();
        btn_raw = 1'b1;
        step(8);
        btn_raw = 1'b0;
        step(8);
    endtask

    task automatic ack_pulse();
        ped_ack = 1'b1;
        step(1);
        ped_ack = 1'b0;
        step(1);
    endtask

    task automatic walk_phase();
        walk_busy = 1'b1;
        step(5);
        walk_busy = 1'b0;
        step(2);
    endtask

    task automatic one_tick();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            vectors++;
            if ({ped_req, req_led, btn_clean} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: req/led/clean=%b expected 000", i, {ped_req, req_led, btn_clean});
            end
        end
    endtask

    task automatic test_clean_press();
        btn_raw = 1'b1;
        step(1);
        step(5);
        vectors++;
        if (btn_clean !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_early edge5: btn_clean=%b expected 0", btn_clean);
        end
        step(1);
        vectors++;
        if ({btn_clean, ped_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL clean_rise edge6: clean/req=%b expected 10", {btn_clean, ped_req});
        end
        step(1);
        vectors++;
        if ({ped_req, req_led} !== 2'b11) begin
            miscompares++;
            $display("FAIL req_rise edge7: req/led=%b expected 11", {ped_req, req_led});
        end
        step(4);
        ped_ack = 1'b1;
        step(1);
        ped_ack = 1'b0;
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_hold edge12: ped_req=%b expected 1", ped_req);
        end
        step(1);
        vectors++;
        if ({ped_req, req_led} !== 2'b00) begin
            miscompares++;
            $display("FAIL req_fall edge13: req/led=%b expected 00", {ped_req, req_led});
        end
        btn_raw = 1'b0;
        step(8);
        walk_phase();
        one_tick();
        one_tick();
        one_tick();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 30; i++) begin
            btn_raw = i[1];
            step(1);
            vectors++;
            if ({btn_clean, ped_req} !== 2'b00) begin
                miscompares++;
                $display("FAIL bounce cycle %0d: clean/req=%b expected 00", i, {btn_clean, ped_req});
            end
        end
        btn_raw = 1'b0;
        step(10);
        vectors++;
        if ({btn_clean, ped_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL bounce_settle: clean/req=%b expected 00", {btn_clean, ped_req});
        end
    endtask

    task automatic test_gap_with_press();
        press_hold();
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL gp_armed: ped_req=%b expected 1", ped_req);
        end
        ack_pulse();
        walk_phase();
        press_hold();
        one_tick();
        one_tick();
        vectors++;
        if (ped_req !== 1'b0) begin
            miscompares++;
            $display("FAIL gp_in_gap: ped_req=%b expected 0", ped_req);
        end
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        vectors++;
        if ({ped_req, req_led} !== 2'b11) begin
            miscompares++;
            $display("FAIL gp_pending_rearm: req/led=%b expected 11", {ped_req, req_led});
        end
        step(1);
    endtask

    task automatic test_gap_no_press();
        walk_busy = 1'b1;
        step(3);
        walk_busy = 1'b0;
        step(3);
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_armed: ped_req=%b expected 1", ped_req);
        end
        ack_pulse();
        walk_phase();
        one_tick();
        one_tick();
        one_tick();
        step(10);
        vectors++;
        if (ped_req !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_to_idle: ped_req=%b expected 0", ped_req);
        end
        ack_pulse();
        press_hold();
        step(5);
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_press_after_stray_ack: ped_req=%b expected 1", ped_req);
        end
    endtask

    task automatic test_collision_ack_press();
        walk_busy = 1'b1;
        btn_raw = 1'b1;
        step(1);
        step(5);
        ped_ack = 1'b1;
        step(1);
        ped_ack = 1'b0;
        walk_busy = 1'b0;
        step(1);
        vectors++;
        if (ped_req !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_ack_wins: ped_req=%b expected 0", ped_req);
        end
        btn_raw = 1'b0;
        step(8);
        one_tick();
        one_tick();
        one_tick();
        press_hold();
        vectors++;
        if (ped_req !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall_at_entry: ped_req=%b expected 0", ped_req);
        end
        walk_phase();
        one_tick();
        one_tick();
        one_tick();
        step(10);
        vectors++;
        if (ped_req !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_no_second_req: ped_req=%b expected 0", ped_req);
        end
    endtask

    task automatic test_final_tick_press();
        press_hold();
        ack_pulse();
        walk_phase();
        one_tick();
        one_tick();
        btn_raw = 1'b1;
        step(7);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL final_tick_press: ped_req=%b expected 1", ped_req);
        end
        btn_raw = 1'b0;
        step(8);
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL final_tick_hold: ped_req=%b expected 1", ped_req);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        vectors++;
        if ({ped_req, req_led, btn_clean} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_in_armed: req/led/clean=%b expected 000", {ped_req, req_led, btn_clean});
        end
        press_hold();
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_armed_recover: ped_req=%b expected 1", ped_req);
        end
        ack_pulse();
        walk_phase();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        vectors++;
        if (ped_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_gap: ped_req=%b expected 0", ped_req);
        end
        press_hold();
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_gap_recover: ped_req=%b expected 1", ped_req);
        end
        ack_pulse();
        vectors++;
        if (ped_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_gap_recover_ack: ped_req=%b expected 0", ped_req);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_gap_with_press();
        test_gap_no_press();
        test_collision_ack_press();
        test_final_tick_press();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
